// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: word/register widths,
// the reset word value, FSM state encodings and a small alignment helper.
// The misalignment check in mem_access_unit is enabled by defining
// MEM_ALIGN_CHECK_EN at compile time.

`ifndef MEM_ACCESS_UNIT_DEFINES
`define MEM_ACCESS_UNIT_DEFINES
`define WORD_WIDTH 32
`define REG_SIZE   5
`define ZERO_WORD  32'h0000_0000
`define MEM_IDLE   1'b0
`define MEM_ACCESS 1'b1
`endif

package mem_access_unit_pkg;

   typedef enum logic {
      ST_IDLE   = `MEM_IDLE,
      ST_ACCESS = `MEM_ACCESS
   } mem_state_e;

   // True when any of the low align_bits address bits is set.
   function automatic logic addr_misaligned(input logic [`WORD_WIDTH-1:0] addr,
                                            input int align_bits);
      logic m;
      m = 1'b0;
      for (int i = 0; i < `WORD_WIDTH; i++) begin
         if ((i < align_bits) && addr[i]) begin
            m = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register. 'en' captures a completed instruction,
// 'bubble' forces the write enable low while the payload is held.
// misalignW only survives one cycle: any edge without a capture clears it.

import mem_access_unit_pkg::*;

module mem_wb (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   bubble,
   input  logic                   rf_we_in,
   input  logic [`REG_SIZE-1:0]   rd_in,
   input  logic [`WORD_WIDTH-1:0] result_in,
   input  logic                   misalign_in,
   output logic                   Regfile_weW,
   output logic [`REG_SIZE-1:0]   writeRegAddrW,
   output logic [`WORD_WIDTH-1:0] resultW,
   output logic                   misalignW
);

   logic                   we_q,  we_d;
   logic [`REG_SIZE-1:0]   rd_q,  rd_d;
   logic [`WORD_WIDTH-1:0] res_q, res_d;
   logic                   mis_q, mis_d;

   // Select capture, bubble or hold for the next register contents.
   always_comb begin
      we_d  = we_q;
      rd_d  = rd_q;
      res_d = res_q;
      mis_d = 1'b0;
      if (en) begin
         we_d  = rf_we_in;
         rd_d  = rd_in;
         res_d = result_in;
         mis_d = misalign_in;
      end else if (bubble) begin
         we_d  = 1'b0;
      end
   end

   // MEM/WB state, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q  <= 1'b0;
         rd_q  <= '0;
         res_q <= `ZERO_WORD;
         mis_q <= 1'b0;
      end else begin
         we_q  <= we_d;
         rd_q  <= rd_d;
         res_q <= res_d;
         mis_q <= mis_d;
      end
   end

   assign Regfile_weW   = we_q;
   assign writeRegAddrW = rd_q;
   assign resultW       = res_q;
   assign misalignW     = mis_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues data-memory requests with a req/ready
// handshake, stalls upstream while an access is outstanding and feeds the
// MEM/WB register. Define MEM_ALIGN_CHECK_EN to reject misaligned memops
// (no request, misalignW pulse) instead of passing the address through.

import mem_access_unit_pkg::*;

module mem_access_unit #(
   parameter int ALIGN_BITS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   Regfile_weM,
   input  logic                   DataMem_weM,
   input  logic                   DataMem_reM,
   input  logic [`REG_SIZE-1:0]   writeRegAddrM,
   input  logic [`WORD_WIDTH-1:0] aluOutM,
   input  logic [`WORD_WIDTH-1:0] writeDataM,
   output logic                   stallM,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [`WORD_WIDTH-1:0] dmem_addr,
   output logic [`WORD_WIDTH-1:0] dmem_wdata,
   input  logic                   dmem_ready,
   input  logic [`WORD_WIDTH-1:0] dmem_rdata,
   output logic                   Regfile_weW,
   output logic [`REG_SIZE-1:0]   writeRegAddrW,
   output logic [`WORD_WIDTH-1:0] resultW,
   output logic                   misalignW
);

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   mem_state_e             state_q, state_d;
   logic                   req_q,   req_d;
   logic                   we_q,    we_d;
   logic [`WORD_WIDTH-1:0] addr_q,  addr_d;
   logic [`WORD_WIDTH-1:0] wdata_q, wdata_d;

   logic                   memop;
   logic                   misalign;
   logic                   stall_c;
   logic                   wb_en;
   logic                   wb_bubble;
   logic                   wb_we;
   logic [`WORD_WIDTH-1:0] wb_result;
   logic                   wb_mis;

   assign memop    = DataMem_weM | DataMem_reM;
   assign misalign = ALIGN_CHECK && memop && addr_misaligned(aluOutM, ALIGN_BITS);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: start an access on a valid memop, finish on ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (memop && !misalign) state_d = ST_ACCESS;
         ST_ACCESS: if (dmem_ready)         state_d = ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: stall, bus register updates and MEM/WB control.
   always_comb begin
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      stall_c   = 1'b0;
      wb_en     = 1'b0;
      wb_bubble = 1'b0;
      wb_we     = Regfile_weM;
      wb_result = aluOutM;
      wb_mis    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (memop && !misalign) begin
               // Store wins when both enables are set.
               stall_c   = 1'b1;
               req_d     = 1'b1;
               we_d      = DataMem_weM;
               addr_d    = aluOutM;
               wdata_d   = writeDataM;
               wb_bubble = 1'b1;
            end else begin
               wb_en  = 1'b1;
               wb_we  = Regfile_weM & ~misalign;
               wb_mis = misalign;
            end
         end
         ST_ACCESS: begin
            if (!dmem_ready) begin
               stall_c   = 1'b1;
               wb_bubble = 1'b1;
            end else begin
               req_d     = 1'b0;
               wb_en     = 1'b1;
               wb_result = we_q ? aluOutM : dmem_rdata;
            end
         end
         default: begin
            req_d = 1'b0;
         end
      endcase
   end

   // Registered memory bus; reset abandons any request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= `ZERO_WORD;
         wdata_q <= `ZERO_WORD;
      end else begin
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Stall is released immediately while reset is held.
   assign stallM     = stall_c & ~rst;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;

   mem_wb u_mem_wb (
      .clk           (clk),
      .rst           (rst),
      .en            (wb_en),
      .bubble        (wb_bubble),
      .rf_we_in      (wb_we),
      .rd_in         (writeRegAddrM),
      .result_in     (wb_result),
      .misalign_in   (wb_mis),
      .Regfile_weW   (Regfile_weW),
      .writeRegAddrW (writeRegAddrW),
      .resultW       (resultW),
      .misalignW     (misalignW)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes expected MEM/WB
// results and bus requests into queues; a WB monitor and a memory model pop
// and compare independently.

module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        Regfile_weM, DataMem_weM, DataMem_reM;
   logic [4:0]  writeRegAddrM;
   logic [31:0] aluOutM, writeDataM;
   logic        stallM, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        Regfile_weW;
   logic [4:0]  writeRegAddrW;
   logic [31:0] resultW;
   logic        misalignW;

   mem_access_unit dut (
      .clk           (clk),
      .rst           (rst),
      .Regfile_weM   (Regfile_weM),
      .DataMem_weM   (DataMem_weM),
      .DataMem_reM   (DataMem_reM),
      .writeRegAddrM (writeRegAddrM),
      .aluOutM       (aluOutM),
      .writeDataM    (writeDataM),
      .stallM        (stallM),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_ready    (dmem_ready),
      .dmem_rdata    (dmem_rdata),
      .Regfile_weW   (Regfile_weW),
      .writeRegAddrW (writeRegAddrW),
      .resultW       (resultW),
      .misalignW     (misalignW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        mis;
      int          stalls;
   } wb_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdata;
   } bus_exp_t;

   wb_exp_t  wb_q[$];
   bus_exp_t bus_q[$];

   int   errors = 0;
   int   checks = 0;
   logic instr_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // WB monitor: a cycle with stallM=0 captures; check the result one cycle later.
   logic    pending = 1'b0;
   logic    prev_stall = 1'b0;
   int      stall_cnt = 0;
   int      cap_stalls = 0;
   wb_exp_t e;
   always @(negedge clk) begin
      if (rst) begin
         pending    = 1'b0;
         prev_stall = 1'b0;
         stall_cnt  = 0;
      end else begin
         if (pending) begin
            pending = 1'b0;
            if (wb_q.size() == 0) begin
               errors++; checks++;
               $display("FAIL wb_unexpected: got capture expected none at %0t", $time);
            end else begin
               e = wb_q.pop_front();
               chk("wb_we",     {31'b0, Regfile_weW}, {31'b0, e.we});
               chk("wb_rd",     {27'b0, writeRegAddrW}, {27'b0, e.rd});
               chk("wb_result", resultW, e.res);
               chk("wb_mis",    {31'b0, misalignW}, {31'b0, e.mis});
               chk("stall_cycles", cap_stalls, e.stalls);
               $display("WB  we=%0b rd=%0d result=%h mis=%0b stalls=%0d", Regfile_weW,
                        writeRegAddrW, resultW, misalignW, cap_stalls);
            end
         end else if (prev_stall) begin
            chk("bubble_we",  {31'b0, Regfile_weW}, 32'd0);
            chk("bubble_mis", {31'b0, misalignW}, 32'd0);
         end
         prev_stall = 1'b0;
         if (instr_valid) begin
            if (stallM) begin
               stall_cnt++;
               prev_stall = 1'b1;
            end else begin
               pending    = 1'b1;
               cap_stalls = stall_cnt;
               stall_cnt  = 0;
            end
         end
      end
   end

   // Memory model: answers each request after its configured wait count and
   // raises ready spuriously while idle, which the unit must ignore.
   logic     mem_active = 1'b0;
   logic     just_done  = 1'b0;
   int       mem_cnt    = 0;
   bus_exp_t cur;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_active = 1'b0;
         just_done  = 1'b0;
         dmem_ready = 1'b0;
         dmem_rdata = 32'h0;
         bus_q.delete();
      end else begin
         #1;
         if (just_done) begin
            just_done = 1'b0;
            chk("req_drop", {31'b0, dmem_req}, 32'd0);
            dmem_ready = 1'b1;
            dmem_rdata = 32'hFFFF_0000;
         end else if (dmem_req) begin
            if (!mem_active) begin
               if (bus_q.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL bus_unexpected: got req addr=%h expected none", dmem_addr);
                  cur.we = dmem_we; cur.addr = dmem_addr; cur.wdata = dmem_wdata;
                  cur.waits = 0; cur.rdata = 32'h0;
               end else begin
                  cur = bus_q.pop_front();
               end
               mem_active = 1'b1;
               mem_cnt    = 0;
            end
            chk("bus_we",    {31'b0, dmem_we}, {31'b0, cur.we});
            chk("bus_addr",  dmem_addr, cur.addr);
            chk("bus_wdata", dmem_wdata, cur.wdata);
            if (mem_cnt >= cur.waits) begin
               dmem_ready = 1'b1;
               dmem_rdata = cur.rdata;
               mem_active = 1'b0;
               just_done  = 1'b1;
               $display("BUS we=%0b addr=%h wdata=%h rdata=%h waits=%0d", dmem_we, dmem_addr,
                        dmem_wdata, cur.rdata, cur.waits);
            end else begin
               dmem_ready = 1'b0;
               dmem_rdata = 32'h0BAD_0000 | mem_cnt;
               mem_cnt++;
            end
         end else begin
            dmem_ready = 1'b1;
            dmem_rdata = 32'hFFFF_0000;
         end
      end
   end

   task automatic drive_nop();
      Regfile_weM   = 1'b0;
      DataMem_weM   = 1'b0;
      DataMem_reM   = 1'b0;
      writeRegAddrM = 5'd0;
      aluOutM       = 32'h0;
      writeDataM    = 32'h0;
   endtask

   // Present one instruction, record expectations, hold it until stallM drops.
   task automatic issue(input logic rf_we, input logic mwe, input logic mre,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                        input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_res, input logic exp_we, input logic exp_mis,
                        input int exp_stalls, input logic exp_bus);
      wb_exp_t  w;
      bus_exp_t b;
      int       n;
      w.we = exp_we; w.rd = rd; w.res = exp_res; w.mis = exp_mis; w.stalls = exp_stalls;
      wb_q.push_back(w);
      if (exp_bus) begin
         b.we = mwe; b.addr = alu; b.wdata = wd; b.waits = waits; b.rdata = rdata;
         bus_q.push_back(b);
      end
      Regfile_weM   = rf_we;
      DataMem_weM   = mwe;
      DataMem_reM   = mre;
      writeRegAddrM = rd;
      aluOutM       = alu;
      writeDataM    = wd;
      instr_valid   = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (!stallM) break;
         n++;
         if (n > 50) begin
            errors++; checks++;
            $display("FAIL stall_timeout: got stallM=1 for %0d cycles expected release", n);
            break;
         end
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int cycles);
      drive_nop();
      instr_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      errors++; checks++;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a memop pending on the inputs: stall must stay low.
      rst = 1'b1;
      drive_nop();
      DataMem_reM = 1'b1;
      aluOutM     = 32'h0000_0010;
      #12;
      chk("rst_stallM",   {31'b0, stallM}, 32'd0);
      chk("rst_req",      {31'b0, dmem_req}, 32'd0);
      chk("rst_we",       {31'b0, dmem_we}, 32'd0);
      chk("rst_addr",     dmem_addr, 32'd0);
      chk("rst_wdata",    dmem_wdata, 32'd0);
      chk("rst_wb_we",    {31'b0, Regfile_weW}, 32'd0);
      chk("rst_wb_rd",    {27'b0, writeRegAddrW}, 32'd0);
      chk("rst_wb_res",   resultW, 32'd0);
      chk("rst_wb_mis",   {31'b0, misalignW}, 32'd0);
      drive_nop();
      rst = 1'b0;
      @(posedge clk);
      #2;

      // ALU pass-through.
      issue(1, 0, 0, 5'd5, 32'h0000_1234, 32'h0, 0, 32'h0, 32'h0000_1234, 1, 0, 0, 0);
      // Load with 3 wait states.
      issue(1, 0, 1, 5'd7, 32'h0000_0100, 32'h1111_2222, 3, 32'hDEAD_BEEF,
            32'hDEAD_BEEF, 1, 0, 4, 1);
      // Store with immediate ready.
      issue(0, 1, 0, 5'd0, 32'h0000_0040, 32'hCAFE_F00D, 0, 32'h0,
            32'h0000_0040, 0, 0, 1, 1);
      // Back-to-back load right after the store.
      issue(1, 0, 1, 5'd9, 32'h0000_0200, 32'h0, 1, 32'h1234_5678,
            32'h1234_5678, 1, 0, 2, 1);
      // Both enables set: store, result is the ALU value.
      issue(1, 1, 1, 5'd3, 32'h0000_0080, 32'h55AA_55AA, 2, 32'hBAD0_BAD0,
            32'h0000_0080, 1, 0, 3, 1);
      // r0 destination passes through unchanged.
      issue(1, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'h0, 0, 32'h0, 32'hFFFF_FFFF, 1, 0, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
      // Misaligned load: no request, no stall, one-cycle flag.
      issue(1, 0, 1, 5'd4, 32'h0000_0102, 32'h0, 0, 32'h0BEE_F102,
            32'h0000_0102, 0, 1, 0, 0);
`else
      // Without the check the address goes out unchanged.
      issue(1, 0, 1, 5'd4, 32'h0000_0102, 32'h0, 0, 32'h0BEE_F102,
            32'h0BEE_F102, 1, 0, 1, 1);
`endif
      // Following plain op sees misalignW cleared.
      issue(0, 0, 0, 5'd2, 32'h0000_0007, 32'h0, 0, 32'h0, 32'h0000_0007, 0, 0, 0, 0);
      idle(3);
      chk("wb_queue_empty",  wb_q.size(), 32'd0);
      chk("bus_queue_empty", bus_q.size(), 32'd0);

      // Asynchronous reset in the middle of a long access.
      begin
         bus_exp_t b;
         b.we = 1'b0; b.addr = 32'h0000_0300; b.wdata = 32'h0; b.waits = 100; b.rdata = 32'h0;
         bus_q.push_back(b);
      end
      Regfile_weM   = 1'b1;
      DataMem_reM   = 1'b1;
      writeRegAddrM = 5'd8;
      aluOutM       = 32'h0000_0300;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_req",   {31'b0, dmem_req}, 32'd1);
      chk("pre_rst_stall", {31'b0, stallM}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_req",   {31'b0, dmem_req}, 32'd0);
      chk("async_rst_stall", {31'b0, stallM}, 32'd0);
      chk("async_rst_wb_we", {31'b0, Regfile_weW}, 32'd0);
      chk("async_rst_res",   resultW, 32'd0);
      drive_nop();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;
      // Back in IDLE: a plain op flows through with no stall.
      issue(1, 0, 0, 5'd31, 32'hA5A5_0001, 32'h0, 0, 32'h0, 32'hA5A5_0001, 1, 0, 0, 0);
      // And a fresh load completes normally.
      issue(1, 0, 1, 5'd12, 32'h0000_0404, 32'h0, 0, 32'h7777_8888,
            32'h7777_8888, 1, 0, 1, 1);
      idle(3);
      chk("final_wb_queue_empty",  wb_q.size(), 32'd0);
      chk("final_bus_queue_empty", bus_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
